// File: rtl/rotate_sched_pkg.sv
// Shared definitions for the two-requester rotate scheduler: FSM state
// encoding and default word/step-count widths.
package rotate_sched_pkg;

    localparam int DW_DEFAULT = 4;
    localparam int CW_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

endpackage

// File: rtl/rot4_step.sv
// Single-position rotate of a 4-bit word; passes the word through when idle.
module rot4_step (
    input  logic       en,
    input  logic       dir,
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // One step left (dir=1) or right (dir=0), or pass-through
    always_comb begin
        dout = din;
        if (!en) begin
            dout = din;
        end else if (dir) begin
            dout = {din[2:0], din[3]};
        end else begin
            dout = {din[0], din[3:1]};
        end
    end

endmodule

// File: rtl/rotate_scheduler.sv
// Round-robin arbiter for two rotate requesters feeding a one-step-per-cycle
// rotator; one command in flight, result held until the consumer takes it.
module rotate_scheduler
    import rotate_sched_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_data,
    input  logic          req0_dir,
    input  logic [CW-1:0] req0_cnt,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_data,
    input  logic          req1_dir,
    input  logic [CW-1:0] req1_cnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_id,
    output logic          busy
);

    sched_state_e  state_r, state_next_s;
    logic [DW-1:0] work_r, work_next_s;
    logic [CW-1:0] cnt_r, cnt_next_s;
    logic          dir_r, dir_next_s;
    logic          id_r, id_next_s;
    logic          last_r, last_next_s;
    logic          grant_s;
    logic          step_en_s;
    logic [DW-1:0] step_dout_s;
    logic          out_valid_r;
    logic [DW-1:0] out_data_r;
    logic          busy_r;

    assign step_en_s = (state_r == ROT);

    rot4_step u_step (
        .en   (step_en_s),
        .dir  (dir_r),
        .din  (work_r),
        .dout (step_dout_s)
    );

    // Arbitration: a tie goes to the requester not granted last
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state, command capture and handshake logic
    always_comb begin
        state_next_s = state_r;
        work_next_s  = work_r;
        cnt_next_s   = cnt_r;
        dir_next_s   = dir_r;
        id_next_s    = id_r;
        last_next_s  = last_r;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready = ~grant_s;
                    req1_ready = grant_s;
                    id_next_s  = grant_s;
                    if (grant_s) begin
                        work_next_s = req1_data;
                        dir_next_s  = req1_dir;
                        cnt_next_s  = req1_cnt;
                    end else begin
                        work_next_s = req0_data;
                        dir_next_s  = req0_dir;
                        cnt_next_s  = req0_cnt;
                    end
                    if (cnt_next_s == CW'(0)) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = ROT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ROT: begin
                work_next_s = step_dout_s;
                cnt_next_s  = cnt_r - CW'(1);
                // Leave on the final step so the result is valid right after it
                if (cnt_r <= CW'(1)) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ROT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                    last_next_s  = id_r;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, working word and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            work_r      <= '0;
            cnt_r       <= '0;
            dir_r       <= 1'b0;
            id_r        <= 1'b0;
            last_r      <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            work_r      <= work_next_s;
            cnt_r       <= cnt_next_s;
            dir_r       <= dir_next_s;
            id_r        <= id_next_s;
            last_r      <= last_next_s;
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s != IDLE);
            if ((state_r != DONE) && (state_next_s == DONE)) begin
                out_data_r <= work_next_s;
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_id    = id_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_rotate_scheduler.sv
// Self-checking bench for rotate_scheduler: vector table plus arbitration,
// back-pressure and mid-operation reset sequences, scoreboard-checked.
module tb_rotate_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_dir;
    logic [3:0] req0_data;
    logic [2:0] req0_cnt;
    logic       req1_valid, req1_ready, req1_dir;
    logic [3:0] req1_data;
    logic [2:0] req1_cnt;
    logic       out_valid, out_ready, out_id, busy;
    logic [3:0] out_data;

    always #5 clk = ~clk;

    rotate_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_dir   (req0_dir),
        .req0_cnt   (req0_cnt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_dir   (req1_dir),
        .req1_cnt   (req1_cnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .busy       (busy)
    );

    typedef struct {
        logic       id;
        logic [3:0] data;
        logic       dir;
        logic [2:0] cnt;
        logic [3:0] exp_data;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic       id;
        int         lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference rotate: take 4 bits out of the doubled word
    function automatic logic [3:0] rot_model(input logic [3:0] d, input logic dir, input logic [2:0] cnt);
        logic [7:0] dd;
        int k;
        dd = {d, d};
        k  = int'(cnt) % 4;
        dd = dd >> (dir ? (4 - k) : k);
        return dd[3:0];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive_req(input logic id, input logic [3:0] d, input logic dir, input logic [2:0] cnt);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_data = d; req0_dir = dir; req0_cnt = cnt;
        end else begin
            req1_valid = 1'b1; req1_data = d; req1_dir = dir; req1_cnt = cnt;
        end
    endtask

    // Starts at posedge+1 with the DUT idle; ends at posedge+1 back in IDLE
    task automatic run_cmd(input vec_t v, input string tag);
        exp_t e;
        int   w;
        int   lat;
        logic rdy;
        drive_req(v.id, v.data, v.dir, v.cnt);
        w = 0;
        #1;
        rdy = v.id ? req1_ready : req0_ready;
        while (!rdy && w < 20) begin
            @(posedge clk); #1;
            rdy = v.id ? req1_ready : req0_ready;
            w++;
        end
        if (!rdy) begin
            check({tag, "_ready_timeout"}, 32'd0, 32'd1);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        e.data = v.exp_data; e.id = v.id; e.lat = 1 + int'(v.cnt);
        sb.push_back(e);
        @(posedge clk); #1;
        // Scramble the requester's inputs after the transfer
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 4'($urandom); req0_dir = 1'($urandom); req0_cnt = 3'($urandom);
        req1_data = 4'($urandom); req1_dir = 1'($urandom); req1_cnt = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        check({tag, "_data"}, 32'(out_data), 32'(e.data));
        check({tag, "_id"}, 32'(out_id), 32'(e.id));
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle_after_accept"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   n;
        int   w;
        logic acc_prev;
        logic saw;
        logic order [3];
        vec_t v;

        req0_valid = 1'b0; req0_data = 4'd0; req0_dir = 1'b0; req0_cnt = 3'd0;
        req1_valid = 1'b0; req1_data = 4'd0; req1_dir = 1'b0; req1_cnt = 3'd0;
        out_ready = 1'b0;

        tbl[0] = '{1'b0, 4'b1001, 1'b1, 3'd1, 4'b0011};
        tbl[1] = '{1'b1, 4'b1001, 1'b0, 3'd3, 4'b0011};
        tbl[2] = '{1'b1, 4'b1001, 1'b0, 3'd0, 4'b1001};
        tbl[3] = '{1'b0, 4'b0001, 1'b1, 3'd5, 4'b0010};
        tbl[4] = '{1'b1, 4'b0110, 1'b1, 3'd2, 4'b1001};
        tbl[5] = '{1'b0, 4'b1000, 1'b0, 3'd1, 4'b0100};
        tbl[6] = '{1'b0, 4'b0001, 1'b1, 3'd7, 4'b1000};
        tbl[7] = '{1'b1, 4'b1011, 1'b0, 3'd4, 4'b1011};
        for (int i = 8; i < 12; i++) begin
            tbl[i].id   = 1'($urandom);
            tbl[i].data = 4'($urandom);
            tbl[i].dir  = 1'($urandom);
            tbl[i].cnt  = 3'($urandom);
            tbl[i].exp_data = rot_model(tbl[i].data, tbl[i].dir, tbl[i].cnt);
        end

        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_cmd(tbl[i], $sformatf("vec%0d", i));
        end

        // Both requesters held valid: expect req0, req1, req0
        do_reset();
        order[0] = 1'b0; order[1] = 1'b1; order[2] = 1'b0;
        drive_req(1'b0, 4'b1001, 1'b1, 3'd1);
        drive_req(1'b1, 4'b1000, 1'b0, 3'd2);
        n = 0;
        acc_prev = 1'b0;
        for (int c = 0; c < 60 && n < 3; c++) begin
            #1;
            if (acc_prev) check("arb_idle_gap", 32'(busy), 32'd0);
            acc_prev = 1'b0;
            if (busy) check("arb_ready_low_busy", 32'({req0_ready, req1_ready}), 32'd0);
            if (req0_valid && req0_ready) begin
                e.data = 4'b0011; e.id = 1'b0; e.lat = 0; sb.push_back(e);
            end
            if (req1_valid && req1_ready) begin
                e.data = 4'b0010; e.id = 1'b1; e.lat = 0; sb.push_back(e);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("arb_sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("arb_data", 32'(out_data), 32'(e.data));
                    check("arb_id", 32'(out_id), 32'(e.id));
                end
                check("arb_order", 32'(out_id), 32'(order[n]));
                n++;
                out_ready = 1'b1;
                acc_prev = 1'b1;
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
            if (n == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("arb_count", 32'(n), 32'd3);
        check("arb_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;

        // Back-pressure in DONE with both requesters pushing
        drive_req(1'b0, 4'b0001, 1'b1, 3'd2);
        #1;
        check("hold_ready0", 32'(req0_ready), 32'd1);
        e.data = 4'b0100; e.id = 1'b0; e.lat = 3; sb.push_back(e);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        w = 1;
        while (!out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        e = sb.pop_front();
        check("hold_latency", 32'(w), 32'(e.lat));
        req0_valid = 1'b1;
        drive_req(1'b1, 4'b1111, 1'b0, 3'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_data", 32'(out_data), 32'(e.data));
            check("hold_out_id", 32'(out_id), 32'(e.id));
            check("hold_readies", 32'({req0_ready, req1_ready}), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_released", 32'(out_valid), 32'd0);

        // Reset during ROT drops the operation
        drive_req(1'b1, 4'b0001, 1'b1, 3'd5);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_in_rot", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data", 32'(out_data), 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            saw = saw | out_valid;
        end
        check("abort_no_result", 32'(saw), 32'd0);
        v = '{1'b0, 4'b0001, 1'b1, 3'd5, 4'b0010};
        run_cmd(v, "post_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rotate_scheduler.md
ROTATE_SCHEDULER -- requirements
Module: rotate_scheduler

Interface
REQ-001 SHALL have parameter DW, default 4, rotated word width (only DW=4 is supported).
REQ-002 SHALL have parameter CW, default 3, step-count width (0..7 steps).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports reqN_valid  input  1  requester N command valid, for N=0,1.
REQ-006 SHALL have ports reqN_ready  output  1  requester N command accepted, for N=0,1.
REQ-007 SHALL have ports reqN_data  input  DW  word to rotate, for N=0,1.
REQ-008 SHALL have ports reqN_dir  input  1  1=left, 0=right, for N=0,1.
REQ-009 SHALL have ports reqN_cnt  input  CW  number of one-position steps, for N=0,1.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_data  output  DW  rotated result.
REQ-013 SHALL have port out_id  output  1  index of the requester that owns the result.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ROT, DONE.
REQ-016 In IDLE, the arbiter SHALL grant one valid requester; a lone valid requester wins; if both are valid, the requester not granted last wins (round-robin).
REQ-017 reqN_ready SHALL be combinational: high only in IDLE for the granted N; a transfer occurs when valid and ready are both high.
REQ-018 On transfer, the block SHALL capture data, dir, cnt and id; next state is DONE if cnt==0, else ROT.
REQ-019 In ROT, each cycle SHALL rotate the working word by one position in the latched direction (left: {d[2:0],d[3]}; right: {d[0],d[3:1]}) and decrement the remaining count.
REQ-020 The FSM SHALL leave ROT for DONE in the cycle the final step is applied; counts of 4 or more wrap naturally (left 5 == left 1).
REQ-021 In DONE, out_valid SHALL be 1 and out_data/out_id SHALL be stable until out_valid&&out_ready; the FSM then returns to IDLE and updates the last-grant pointer.
REQ-022 Latency: a transfer at edge T SHALL give out_valid at T+1+cnt; cnt==0 passes data unchanged at T+1.
REQ-023 No new command SHALL be accepted outside IDLE; both ready outputs SHALL be low in ROT and DONE.
REQ-024 A command accepted at the edge where DONE completes SHALL NOT occur; IDLE lasts at least one cycle between results.
REQ-025 Input changes on a requester after its transfer SHALL NOT affect the operation in flight.

Reset
REQ-026 When rst_n is low at a clk edge, state SHALL be IDLE, out_valid=0, out_data=0, out_id=0, the remaining count 0, and the last-grant pointer 1 (req0 wins the first tie).
REQ-027 A reset during ROT or DONE SHALL abort and drop the operation with no result emitted.

Structure
REQ-028 The FSM state enum and the DW/CW defaults SHALL be placed in shared package rotate_sched_pkg.
REQ-029 The single-step rotation SHALL be a sub-module rot4_step (inputs en, dir, din; output dout; pass-through when en=0), instantiated once.

Verification
REQ-030 req0: data=4'b1001, dir=1, cnt=1 -> out_data=4'b0011, out_id=0, out_valid 2 cycles after transfer.
REQ-031 req1: data=4'b1001, dir=0, cnt=3 -> out_data=4'b0011, out_id=1, out_valid 4 cycles after transfer; cnt=0 -> 4'b1001 after 1 cycle.
REQ-032 req0 and req1 valid together after reset -> req0 served first, then req1; a second simultaneous pair -> req0 served again only after req1's turn.
REQ-033 out_ready held low 3 cycles in DONE -> out_valid, out_data and out_id stable, both ready outputs low, busy=1.
REQ-034 rst_n low mid-ROT with cnt=5 -> the next cycle shows IDLE, out_valid=0 and no result; a following command completes correctly.
REQ-035 data=4'b0001, dir=1, cnt=5 -> out_data=4'b0010 (wrap-around).
